// File: rtl/dw_tap_pkg.sv
// Shared types for the boundary-scan TAP controller.
// State codes follow the standard 1149.1 TAP encoding.
package dw_tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

  localparam logic [3:0] OP_EXTEST_DEF = 4'b0000;
  localparam logic [3:0] OP_SAMPLE_DEF = 4'b0001;
  localparam logic [3:0] OP_INTEST_DEF = 4'b0010;
  localparam logic [3:0] OP_IDCODE_DEF = 4'b0011;
  localparam logic [3:0] OP_BYPASS_DEF = 4'b1111;

  typedef enum logic [1:0] {
    SEL_BSR,
    SEL_BYP,
    SEL_IDC
  } dr_sel_t;

endpackage

// File: rtl/dw_tap_fsm.sv
// 16-state TAP controller state register and next-state graph.
// Five tms=1 edges from any state land in TLR.
module dw_tap_fsm
  import dw_tap_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t tap_state
);

  tap_state_t nxt;

  always_ff @(posedge tck) begin
    if (rst) tap_state <= TLR;
    else     tap_state <= nxt;
  end

  always_comb begin
    nxt = tap_state;
    unique case (tap_state)
      TLR:    nxt = tms ? TLR    : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR    : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

endmodule

// File: rtl/dw_tap_bc_ctrl.sv
// TAP controller driving a BC_5 boundary-scan chain: IR, bypass, decode.
// Define DW_TAP_IDCODE_EN to add the 32-bit IDCODE register.
module dw_tap_bc_ctrl
  import dw_tap_pkg::*;
#(
  parameter int IR_WIDTH = 4,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(OP_EXTEST_DEF),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(OP_SAMPLE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_INTEST = IR_WIDTH'(OP_INTEST_DEF),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(OP_IDCODE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS = '1,
  parameter logic [31:0]         IDCODE_VAL = 32'h0000_0001
) (
  input  logic                tck,
  input  logic                rst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic                bsr_si,
  input  logic                bsr_so,
  output logic                shift_dr,
  output logic                capture_en,
  output logic                update_en,
  output logic                mode,
  output logic                intest,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_q
);

  if (IR_WIDTH < 2) begin : g_bad_width
    $error("IR_WIDTH must be at least 2");
  end
  if (OP_BYPASS != '1) begin : g_bad_bypass
    $error("OP_BYPASS must be all ones");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
    $error("IDCODE_VAL bit 0 must be 1");
  end

`ifdef DW_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_DEF = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_DEF = OP_BYPASS;
`endif
  localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(2'b01);

  tap_state_t          st;
  dr_sel_t             dr_sel;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass_q;
  logic                bsr_sel;

  dw_tap_fsm u_fsm (
    .tck       (tck),
    .rst       (rst),
    .tms       (tms),
    .tap_state (st)
  );

  assign tap_state = st;
  assign bsr_si    = tdi;

  // ir_q only moves on leaving UpdIR or while sitting in TLR
  always_ff @(posedge tck) begin
    if (rst) begin
      ir_sr <= '0;
      ir_q  <= IR_DEF;
    end else begin
      case (st)
        CAP_IR:  ir_sr <= IR_CAP;
        SH_IR:   ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        UPD_IR:  ir_q  <= ir_sr;
        TLR:     ir_q  <= IR_DEF;
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck) begin
    if (rst)               bypass_q <= 1'b0;
    else if (st == CAP_DR) bypass_q <= 1'b0;
    else if (st == SH_DR)  bypass_q <= tdi;
  end

`ifdef DW_TAP_IDCODE_EN
  logic [31:0] id_sr;

  always_ff @(posedge tck) begin
    if (st == CAP_DR)     id_sr <= IDCODE_VAL;
    else if (st == SH_DR) id_sr <= {tdi, id_sr[31:1]};
  end
`endif

  always_comb begin
    dr_sel = SEL_BYP;
    unique case (1'b1)
      (ir_q == OP_EXTEST),
      (ir_q == OP_SAMPLE),
      (ir_q == OP_INTEST): dr_sel = SEL_BSR;
`ifdef DW_TAP_IDCODE_EN
      (ir_q == OP_IDCODE): dr_sel = SEL_IDC;
`else
      (ir_q == OP_IDCODE): dr_sel = SEL_BYP;
`endif
      default:             dr_sel = SEL_BYP;
    endcase
  end

  assign bsr_sel    = (dr_sel == SEL_BSR);
  assign shift_dr   = (st == SH_DR) && bsr_sel;
  assign capture_en = !(((st == CAP_DR) || (st == SH_DR)) && bsr_sel);
  assign update_en  = (st == UPD_DR) && bsr_sel;
  assign mode       = (ir_q == OP_EXTEST) || (ir_q == OP_INTEST);
  assign intest     = (ir_q == OP_INTEST);
  assign tdo_en     = (st == SH_DR) || (st == SH_IR);

  always_comb begin
    tdo = 1'b0;
    if (st == SH_IR) begin
      tdo = ir_sr[0];
    end else if (st == SH_DR) begin
      case (dr_sel)
        SEL_BSR: tdo = bsr_so;
`ifdef DW_TAP_IDCODE_EN
        SEL_IDC: tdo = id_sr[0];
`endif
        default: tdo = bypass_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dw_tap_bc_ctrl.sv
// Randomized scoreboard bench for dw_tap_bc_ctrl with a 3-cell BC_5 chain.
// Reference model tracks TAP graph, IR/DR contents as bit queues.
module tb_dw_tap_bc_ctrl;

  localparam int W = 4;
  localparam logic [31:0] IDC = 32'h0000_0001;
  localparam logic [W-1:0] OP_EXT = 4'b0000;
  localparam logic [W-1:0] OP_SMP = 4'b0001;
  localparam logic [W-1:0] OP_INT = 4'b0010;
  localparam logic [W-1:0] OP_IDC = 4'b0011;
  localparam logic [W-1:0] OP_BYP = 4'b1111;
`ifdef DW_TAP_IDCODE_EN
  localparam logic [W-1:0] DEF_IR = OP_IDC;
`else
  localparam logic [W-1:0] DEF_IR = OP_BYP;
`endif

  localparam int S_TLR = 15, S_RTI = 12, S_SDR = 7, S_CDR = 6;
  localparam int S_SHDR = 2, S_E1DR = 1, S_PDR = 3, S_E2DR = 0;
  localparam int S_UDR = 5, S_SIR = 4, S_CIR = 14, S_SHIR = 10;
  localparam int S_E1IR = 9, S_PIR = 11, S_E2IR = 8, S_UIR = 13;

  logic tck = 1'b0, rst = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic tdo, tdo_en, bsr_si, bsr_so, shift_dr, capture_en;
  logic update_en, mode, intest;
  logic [3:0] tap_state;
  logic [W-1:0] ir_q;

  always #5 tck = ~tck;

  dw_tap_bc_ctrl dut (
    .tck        (tck),
    .rst        (rst),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .bsr_si     (bsr_si),
    .bsr_so     (bsr_so),
    .shift_dr   (shift_dr),
    .capture_en (capture_en),
    .update_en  (update_en),
    .mode       (mode),
    .intest     (intest),
    .tap_state  (tap_state),
    .ir_q       (ir_q)
  );

  // external 3-cell chain: cell 0 nearest tdi, cell 2 drives bsr_so
  logic [2:0] cell_cap = '0, cell_upd = '0, din = '0;
  assign bsr_so = cell_cap[2];

  always @(posedge tck) begin
    if (capture_en == 1'b0)
      cell_cap <= shift_dr ? {cell_cap[1:0], bsr_si} : din;
    if (update_en == 1'b1)
      cell_upd <= cell_cap;
  end

  typedef struct {
    logic [3:0]   st;
    logic         sd, ce, ue, md, it, te, tdo;
    logic [W-1:0] ir;
    logic [2:0]   cells;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  int         nx[16][2];
  int         m_st = S_TLR;
  logic [W-1:0] m_ir = DEF_IR;
  bit         m_drq[$];
  bit         m_irq[$];
  logic [2:0] m_cells = '0;

  function automatic void arc(int s, int n0, int n1);
    nx[s][0] = n0;
    nx[s][1] = n1;
  endfunction

  // 0 = boundary chain, 1 = bypass, 2 = id register
  function automatic int sel_of(logic [W-1:0] ir);
    if (ir == OP_EXT || ir == OP_SMP || ir == OP_INT) return 0;
`ifdef DW_TAP_IDCODE_EN
    if (ir == OP_IDC) return 2;
`endif
    return 1;
  endfunction

  function automatic void step_model(bit r, bit m, bit d, logic [2:0] dn);
    int sel;
    if (r) begin
      m_st = S_TLR;
      m_ir = DEF_IR;
      return;
    end
    sel = sel_of(m_ir);
    case (m_st)
      S_CDR: begin
        m_drq.delete();
        if (sel == 0) begin
          m_drq.push_back(dn[2]);
          m_drq.push_back(dn[1]);
          m_drq.push_back(dn[0]);
        end else if (sel == 2) begin
          for (int i = 0; i < 32; i++) m_drq.push_back(IDC[i]);
        end else begin
          m_drq.push_back(1'b0);
        end
      end
      S_SHDR: begin
        if (m_drq.size() > 0) void'(m_drq.pop_front());
        m_drq.push_back(d);
      end
      S_UDR: begin
        if (sel == 0 && m_drq.size() == 3)
          for (int i = 0; i < 3; i++) m_cells[i] = m_drq[2-i];
      end
      S_CIR: begin
        m_irq.delete();
        for (int i = 0; i < W; i++) m_irq.push_back(i == 0);
      end
      S_SHIR: begin
        if (m_irq.size() > 0) void'(m_irq.pop_front());
        m_irq.push_back(d);
      end
      S_UIR: for (int i = 0; i < W; i++) m_ir[i] = m_irq[i];
      S_TLR: m_ir = DEF_IR;
      default: ;
    endcase
    m_st = nx[m_st][m];
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit   bsr;
    bsr = (sel_of(m_ir) == 0);
    e.st    = 4'(m_st);
    e.sd    = (m_st == S_SHDR) && bsr;
    e.ce    = !(((m_st == S_CDR) || (m_st == S_SHDR)) && bsr);
    e.ue    = (m_st == S_UDR) && bsr;
    e.md    = (m_ir == OP_EXT) || (m_ir == OP_INT);
    e.it    = (m_ir == OP_INT);
    e.te    = (m_st == S_SHDR) || (m_st == S_SHIR);
    e.tdo   = 1'b0;
    if (m_st == S_SHDR && m_drq.size() > 0) e.tdo = m_drq[0];
    if (m_st == S_SHIR && m_irq.size() > 0) e.tdo = m_irq[0];
    e.ir    = m_ir;
    e.cells = m_cells;
    return e;
  endfunction

  task automatic drive(input bit r, input bit m, input bit d);
    @(negedge tck);
    #1;
    rst = r;
    tms = m;
    tdi = d;
    din = 3'($urandom);
    step_model(r, m, d, din);
    sb.push_back(expect_now());
  endtask

  task automatic goto_rti();
    if (m_st != S_RTI) begin
      repeat (5) drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic load_ir(input logic [W-1:0] op);
    goto_rti();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) drive(1'b0, i == W - 1, op[i]);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] bits);
    goto_rti();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) drive(1'b0, i == n - 1, bits[i]);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, req, $time);
    end
  endfunction

  always begin : monitor
    exp_t e;
    @(posedge tck);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("tap_state", 32'(tap_state), 32'(e.st));
      chk("shift_dr", 32'(shift_dr), 32'(e.sd));
      chk("capture_en", 32'(capture_en), 32'(e.ce));
      chk("update_en", 32'(update_en), 32'(e.ue));
      chk("mode", 32'(mode), 32'(e.md));
      chk("intest", 32'(intest), 32'(e.it));
      chk("tdo_en", 32'(tdo_en), 32'(e.te));
      chk("tdo", 32'(tdo), 32'(e.tdo));
      chk("ir_q", 32'(ir_q), 32'(e.ir));
      chk("cells", 32'(cell_upd), 32'(e.cells));
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    arc(S_TLR, S_RTI, S_TLR);   arc(S_RTI, S_RTI, S_SDR);
    arc(S_SDR, S_CDR, S_SIR);   arc(S_CDR, S_SHDR, S_E1DR);
    arc(S_SHDR, S_SHDR, S_E1DR); arc(S_E1DR, S_PDR, S_UDR);
    arc(S_PDR, S_PDR, S_E2DR);  arc(S_E2DR, S_SHDR, S_UDR);
    arc(S_UDR, S_RTI, S_SDR);   arc(S_SIR, S_CIR, S_TLR);
    arc(S_CIR, S_SHIR, S_E1IR); arc(S_SHIR, S_SHIR, S_E1IR);
    arc(S_E1IR, S_PIR, S_UIR);  arc(S_PIR, S_PIR, S_E2IR);
    arc(S_E2IR, S_SHIR, S_UIR); arc(S_UIR, S_RTI, S_SDR);

    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    load_ir(OP_EXT);
    scan_dr(3, 64'b101);
    load_ir(OP_BYP);
    scan_dr(3, 64'b011);
    load_ir(4'b0101);
    scan_dr(5, 64'($urandom));
    load_ir(OP_INT);
    scan_dr(3, 64'b010);
    load_ir(OP_SMP);
    scan_dr(3, 64'b110);

    load_ir(OP_EXT);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    scan_dr(32, 64'(IDC));
    load_ir(OP_IDC);
    scan_dr(32, {$urandom, $urandom});

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 2))
        0: load_ir(W'($urandom));
        1: scan_dr(int'($urandom_range(1, 40)), {$urandom, $urandom});
        default: begin
          for (int j = 0; j < 20; j++)
            drive($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom));
        end
      endcase
    end

    repeat (3) @(negedge tck);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
